// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes uart_rx, samples each bit at mid-bit and
// presents bytes on a valid/ready port with framing-error and overrun pulses.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;
    logic [2:0]             state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [2:0]             bit_reg, bit_next;
    logic [7:0]             shreg_reg, shreg_next;
    logic [7:0]             data_reg, data_next;
    logic                   valid_reg, valid_next;
    logic                   ferr_reg, ferr_next;
    logic                   ovr_reg, ovr_next;

    // Synchronizer presets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) sync_reg[0] <= 1'b1;
        else      sync_reg[0] <= uart_rx;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst) sync_reg[gi] <= 1'b1;
                else      sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign rxs = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shreg_next = shreg_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;

        if (valid_reg && rx_ready) valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CW'(HALF - 1)) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = DATA;
                        bit_next   = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    shreg_next = {rxs, shreg_reg[7:1]};
                    if (bit_reg == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next = '0;
                    if (rxs) begin
                        // A same-cycle accept frees the holding register for the new byte.
                        if (!valid_reg || rx_ready) begin
                            data_next  = shreg_reg;
                            valid_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BRK;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            BRK: begin
                if (rxs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= 3'd0;
            shreg_reg <= 8'h00;
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shreg_reg <= shreg_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign overrun   = ovr_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; serial frames are
// driven in absolute time so the baud period can be skewed independently of clk.
module tb_uart_rx_byte;
    localparam int CPB = 16;
    localparam int CLK_P = 10;
    localparam int BIT = CPB * CLK_P;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #(CLK_P/2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event monitor: counts pulses and records every accepted byte.
    int nbytes = 0, nvalid = 0, nferr = 0, novr = 0, nbusy = 0, nboth = 0;
    logic [7:0] acc [0:63];
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) nvalid++;
            if (rx_valid && rx_ready) begin
                acc[nbytes % 64] = rx_data;
                nbytes++;
            end
            if (frame_err) nferr++;
            if (overrun) novr++;
            if (frame_err && overrun) nboth++;
            if (busy) nbusy++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 'h%0h", nm, act);
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop, input int per);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(per);
        end
        uart_rx = stop;
        #(per);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
        @(negedge clk);
        #3;
        uart_rx = 1'b0;
        #(per);
        send_bits(d, stop, per);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_hi;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [8];
    int b_bytes, b_valid, b_ferr, b_ovr, b_busy, lat, dt;
    time t0;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h68, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 0};
        vecs[5] = '{8'hA5, 1'b1, 1, 0};
        vecs[6] = '{8'h5A, 1'b0, 0, 1};
        vecs[7] = '{8'hC3, 1'b1, 1, 0};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        chk("reset busy", busy, 0);
        @(posedge clk); #1 rst = 1'b1;
        #(2*BIT);

        foreach (vecs[k]) begin
            b_bytes = nbytes; b_valid = nvalid; b_ferr = nferr; b_ovr = novr;
            send_frame(vecs[k].data, vecs[k].stop_hi, BIT);
            uart_rx = 1'b1;
            #(2*BIT);
            $display("vector %0d: byte 'h%0h stop %0d", k, vecs[k].data, vecs[k].stop_hi);
            chk("vec bytes", nbytes - b_bytes, vecs[k].exp_bytes);
            if (nbytes - b_bytes == 1 && vecs[k].exp_bytes == 1)
                chk("vec data", acc[(nbytes-1) % 64], vecs[k].data);
            chk("vec valid cycles", nvalid - b_valid, vecs[k].exp_bytes);
            chk("vec frame_err", nferr - b_ferr, vecs[k].exp_ferr);
            chk("vec overrun", novr - b_ovr, 0);
            chk("vec busy idle", busy, 0);
        end

        // Start-bit edge to IDLE exit, then finish the frame on the same bit grid.
        b_bytes = nbytes;
        @(negedge clk); #1;
        t0 = $time;
        uart_rx = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (busy) lat = i;
        end
        chk("start latency", lat, 3);
        dt = BIT - int'($time - t0);
        #(dt);
        send_bits(8'h96, 1'b1, BIT);
        #(2*BIT);
        chk("latency frame bytes", nbytes - b_bytes, 1);
        chk("latency frame data", acc[(nbytes-1) % 64], 8'h96);

        // Back-to-back frames while the consumer stalls.
        @(posedge clk); #1 rx_ready = 1'b0;
        b_bytes = nbytes; b_ovr = novr; b_ferr = nferr;
        send_frame(8'h55, 1'b1, BIT);
        uart_rx = 1'b0;
        #(BIT);
        send_bits(8'hA3, 1'b1, BIT);
        #(2*BIT);
        @(negedge clk);
        chk("b2b held valid", rx_valid, 1);
        chk("b2b held data", rx_data, 8'h55);
        chk("b2b overrun", novr - b_ovr, 1);
        chk("b2b frame_err", nferr - b_ferr, 0);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        chk("b2b valid after accept", rx_valid, 0);
        #(4*BIT);
        chk("b2b bytes", nbytes - b_bytes, 1);
        chk("b2b accepted data", acc[(nbytes-1) % 64], 8'h55);
        @(posedge clk); #1 rx_ready = 1'b1;

        // Bad stop bit followed by a long break.
        b_bytes = nbytes; b_valid = nvalid; b_ferr = nferr;
        send_frame(8'h00, 1'b0, BIT);
        #(40*BIT);
        @(negedge clk);
        chk("break busy", busy, 1);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("break released busy", busy, 0);
        chk("break frame_err", nferr - b_ferr, 1);
        chk("break bytes", nbytes - b_bytes, 0);
        chk("break valid cycles", nvalid - b_valid, 0);

        // Three-cycle glitch: START lasts exactly HALF cycles.
        b_bytes = nbytes; b_ferr = nferr; b_busy = nbusy;
        @(negedge clk); #3 uart_rx = 1'b0;
        #(3*CLK_P);
        uart_rx = 1'b1;
        #(2*BIT);
        chk("glitch busy cycles", nbusy - b_busy, CPB/2);
        chk("glitch bytes", nbytes - b_bytes, 0);
        chk("glitch frame_err", nferr - b_ferr, 0);
        chk("glitch busy", busy, 0);

        // Reset in the middle of data bit 4 of a 0xFF frame.
        b_bytes = nbytes; b_ferr = nferr; b_ovr = novr;
        @(negedge clk); #3 uart_rx = 1'b0;
        #(BIT);
        uart_rx = 1'b1;
        #(4*BIT + BIT/2);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst rx_data", rx_data, 8'h00);
        chk("midrst rx_valid", rx_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst frame_err", frame_err, 0);
        chk("midrst overrun", overrun, 0);
        @(posedge clk); #1 rst = 1'b1;
        #(6*BIT);
        chk("midrst aborted bytes", nbytes - b_bytes, 0);
        send_frame(8'h3C, 1'b1, BIT);
        #(2*BIT);
        chk("midrst next bytes", nbytes - b_bytes, 1);
        chk("midrst next data", acc[(nbytes-1) % 64], 8'h3C);
        chk("midrst errors", (nferr - b_ferr) + (novr - b_ovr), 0);

        // Baud skew of +3% and -3%.
        b_bytes = nbytes; b_ferr = nferr; b_ovr = novr;
        send_frame(8'h68, 1'b1, (BIT * 103) / 100);
        #(2*BIT);
        chk("skew+ bytes", nbytes - b_bytes, 1);
        chk("skew+ data", acc[(nbytes-1) % 64], 8'h68);
        send_frame(8'h68, 1'b1, (BIT * 97) / 100);
        #(2*BIT);
        chk("skew- bytes", nbytes - b_bytes, 2);
        chk("skew- data", acc[(nbytes-1) % 64], 8'h68);
        chk("skew errors", (nferr - b_ferr) + (novr - b_ovr), 0);

        chk("frame_err with overrun", nboth, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
